// File: rtl/qtable_update_ctrl_if.sv
// Request/response and Q-table port bundle for qtable_update_ctrl.
// The controller connects through the slave modport. The requester and table side connect through the master modport.
interface qtable_update_ctrl_if #(
  parameter int STATE_W = 6,
  parameter int DATA_W  = 8
);
  logic               i_valid;
  logic               o_ready;
  logic [STATE_W-1:0] i_state;
  logic [1:0]         i_action;
  logic [DATA_W-1:0]  i_reward;
  logic [STATE_W-1:0] i_next_state;

  logic [STATE_W+1:0] o_tbl_addr_r;
  logic               o_tbl_read_en;
  logic [DATA_W-1:0]  i_tbl_data;
  logic [STATE_W+1:0] o_tbl_addr_w;
  logic               o_tbl_write_en;
  logic [DATA_W-1:0]  o_tbl_data;

  logic               o_done;
  logic [DATA_W-1:0]  o_q_new;
  logic [1:0]         o_max_a;

  modport slave (
    input  i_valid, i_state, i_action, i_reward, i_next_state, i_tbl_data,
    output o_ready, o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en,
           o_tbl_data, o_done, o_q_new, o_max_a
  );

  modport master (
    output i_valid, i_state, i_action, i_reward, i_next_state, i_tbl_data,
    input  o_ready, o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en,
           o_tbl_data, o_done, o_q_new, o_max_a
  );
endinterface

// File: rtl/qtable_update_ctrl.sv
// Sequencer for one shift-based Q-learning update per accepted transition.
// It reads Q(s,a) and Q(s',0..3), folds the values into a greedy max, and writes the clamped result back.
module qtable_update_ctrl #(
  parameter int STATE_W  = 6,
  parameter int DATA_W   = 8,
  parameter int ALPHA_SH = 2,
  parameter int GAMMA_SH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  qtable_update_ctrl_if.slave  bus
);
  localparam int CALC_W = DATA_W + 3;
  localparam logic signed [CALC_W-1:0] Q_MAX = CALC_W'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {
    IDLE, RD_Q, RD_N0, RD_N1, RD_N2, RD_N3, WAIT, WRITE
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d, ns_q, ns_d;
  logic [1:0]         a_q, a_d;
  logic [DATA_W-1:0]  r_q, r_d;
  logic [DATA_W-1:0]  q_sa_q, q_sa_d;
  logic [DATA_W-1:0]  max_val_q, max_val_d;
  logic [1:0]         max_idx_q, max_idx_d;
  logic [DATA_W-1:0]  q_new_q, q_new_d;
  logic [1:0]         max_a_q, max_a_d;

  logic signed [CALC_W-1:0] target, delta, step, sum;
  logic [DATA_W-1:0]        new_val;
  logic [1:0]               fold_idx;

  // Bellman update on zero-extended operands. The arithmetic shift floors negative steps.
  always_comb begin
    target  = $signed({3'b000, r_q}) + $signed({3'b000, max_val_q})
            - $signed({3'b000, max_val_q >> GAMMA_SH});
    delta   = target - $signed({3'b000, q_sa_q});
    step    = delta >>> ALPHA_SH;
    sum     = $signed({3'b000, q_sa_q}) + step;
    if (sum[CALC_W-1])   new_val = '0;
    else if (sum > Q_MAX) new_val = '1;
    else                  new_val = sum[DATA_W-1:0];
  end

  // Read data trails the read enable by one cycle.
  // The value read for Q(s',k) therefore arrives one state after RD_Nk.
  always_comb begin
    unique case (state_q)
      RD_N2:   fold_idx = 2'd1;
      RD_N3:   fold_idx = 2'd2;
      default: fold_idx = 2'd3;
    endcase
  end

  // NOTE: every signal is given its default before the case statement, so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    a_d       = a_q;
    r_d       = r_q;
    ns_d      = ns_q;
    q_sa_d    = q_sa_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    q_new_d   = q_new_q;
    max_a_d   = max_a_q;
    unique case (state_q)
      IDLE: if (bus.i_valid) begin
        s_d     = bus.i_state;
        a_d     = bus.i_action;
        r_d     = bus.i_reward;
        ns_d    = bus.i_next_state;
        state_d = RD_Q;
      end
      RD_Q:  state_d = RD_N0;
      RD_N0: begin
        q_sa_d  = bus.i_tbl_data;
        state_d = RD_N1;
      end
      RD_N1: begin
        max_val_d = bus.i_tbl_data;
        max_idx_d = 2'd0;
        state_d   = RD_N2;
      end
      RD_N2, RD_N3, WAIT: begin
        // Strict compare: on a tie the lower action index keeps the max.
        if (bus.i_tbl_data > max_val_q) begin
          max_val_d = bus.i_tbl_data;
          max_idx_d = fold_idx;
        end
        state_d = (state_q == RD_N2) ? RD_N3 : (state_q == RD_N3) ? WAIT : WRITE;
      end
      WRITE: begin
        q_new_d = new_val;
        max_a_d = max_idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so all flops update together from the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      a_q       <= '0;
      r_q       <= '0;
      ns_q      <= '0;
      q_sa_q    <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      q_new_q   <= '0;
      max_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      a_q       <= a_d;
      r_q       <= r_d;
      ns_q      <= ns_d;
      q_sa_q    <= q_sa_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      q_new_q   <= q_new_d;
      max_a_q   <= max_a_d;
    end
  end

  always_comb begin
    unique case (state_q)
      RD_Q:    bus.o_tbl_addr_r = {s_q, a_q};
      RD_N0:   bus.o_tbl_addr_r = {ns_q, 2'd0};
      RD_N1:   bus.o_tbl_addr_r = {ns_q, 2'd1};
      RD_N2:   bus.o_tbl_addr_r = {ns_q, 2'd2};
      RD_N3:   bus.o_tbl_addr_r = {ns_q, 2'd3};
      default: bus.o_tbl_addr_r = '0;
    endcase
  end

  assign bus.o_ready        = (state_q == IDLE);
  assign bus.o_tbl_read_en  = (state_q inside {RD_Q, RD_N0, RD_N1, RD_N2, RD_N3});
  assign bus.o_tbl_write_en = (state_q == WRITE);
  assign bus.o_done         = (state_q == WRITE);
  assign bus.o_tbl_addr_w   = (state_q == WRITE) ? {s_q, a_q} : '0;
  assign bus.o_tbl_data     = (state_q == WRITE) ? new_val : '0;
  // Result outputs show the new values during WRITE itself. The held copies take over from the next cycle.
  assign bus.o_q_new        = (state_q == WRITE) ? new_val : q_new_q;
  assign bus.o_max_a        = (state_q == WRITE) ? max_idx_q : max_a_q;
endmodule
